// File: rtl/destuf.sv
// rtl/destuf.sv - bit destuffer: strips the 0 inserted after every RUN_LEN consecutive 1s.
// Optional macro DESTUF_ABORT_EN: a stuffing violation discards the rest of the frame.
module destuf #(
    parameter int RUN_LEN = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_in,
    input  logic       data_in,
    output logic       valid_out,
    output logic       data_out,
    output logic       stuff_err,
    output logic [3:0] ones_cnt
);

    typedef enum logic {
        RUN     = 1'b0,
        DISCARD = 1'b1
    } state_t;

    localparam logic [3:0] RUN_LEN_C = 4'(RUN_LEN);

    state_t     state_q;
    logic       valid_out_q;
    logic       data_out_q;
    logic       stuff_err_q;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Next run length for a bit that is forwarded as payload.
    assign cnt_d = data_in ? cnt_q + 4'd1 : 4'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            valid_out_q <= 1'b0;
            data_out_q  <= 1'b0;
            stuff_err_q <= 1'b0;
            cnt_q       <= 4'd0;
        end else begin
            valid_out_q <= 1'b0;
            stuff_err_q <= 1'b0;
            if (!valid_in) begin
                // A gap ends the frame: run length and abort state both restart.
                cnt_q   <= 4'd0;
                state_q <= RUN;
            end else if (state_q == DISCARD) begin
                cnt_q <= 4'd0;
            end else if (cnt_q < RUN_LEN_C) begin
                valid_out_q <= 1'b1;
                data_out_q  <= data_in;
                cnt_q       <= cnt_d;
            end else begin
                // Stuffed position: a 0 is dropped silently, a 1 is a violation.
                cnt_q <= 4'd0;
                if (data_in) begin
                    stuff_err_q <= 1'b1;
`ifdef DESTUF_ABORT_EN
                    state_q <= DISCARD;
`else
                    state_q <= RUN;
`endif
                end
            end
        end
    end

    assign valid_out = valid_out_q;
    assign data_out  = data_out_q;
    assign stuff_err = stuff_err_q;
    assign ones_cnt  = cnt_q;

endmodule

// File: doc/destuf.md
# destuf

Bit destuffer: the receive-side counterpart of the `stuf` bit stuffer. It consumes a serial stream in which a `0` was inserted after every run of `RUN_LEN` consecutive `1`s. It removes each inserted `0` and forwards the original payload bits with a one-cycle registered latency. A `1` where a stuffed `0` is required is a stuffing violation and raises `stuff_err`.

## Interface
- `RUN_LEN`, default 5: count of consecutive `1`s after which the transmitter inserts a `0`. Legal range 2..15.
- `clk`  input  1  sole clock; all logic on posedge.
- `rst`  input  1  synchronous, active-high reset.
- `valid_in`  input  1  `data_in` carries a stuffed-stream bit this cycle.
- `data_in`  input  1  stuffed serial bit (connects to `stuf.stuffed_data`).
- `valid_out`  output  1  `data_out` carries a destuffed payload bit.
- `data_out`  output  1  destuffed serial bit.
- `stuff_err`  output  1  one-cycle pulse on a stuffing violation.
- `ones_cnt`  output  4  current run length of `1`s, for debug and verification.

## Operation
- Internal run counter `cnt` (4 bits) counts consecutive accepted `1`s within a frame. It is exposed as `ones_cnt`.
- A frame is a contiguous stretch of `valid_in`=1. Any cycle with `valid_in`=0 clears `cnt` to 0 and produces no output.
- When `valid_in`=1 and `cnt` < `RUN_LEN`:
  - the bit is forwarded;
  - `data_in`=1 increments `cnt`;
  - `data_in`=0 clears `cnt`.
- When `valid_in`=1 and `cnt` == `RUN_LEN`, the bit is the stuffed position:
  - `data_in`=0: the bit is dropped (`valid_out`=0 next cycle) and `cnt` clears to 0.
  - `data_in`=1: violation. The bit is dropped, `stuff_err` pulses, and `cnt` clears to 0.
- A payload `0` that naturally follows fewer than `RUN_LEN` `1`s is never dropped.
- State machine, 2 states:
  - RUN: normal operation.
  - DISCARD: exists only with the macro; see Configuration.
- Reset state is RUN.

## Timing
- All outputs are registered. A bit sampled at posedge N appears on `data_out`/`valid_out` after posedge N, i.e. it is valid during cycle N+1.
- `stuff_err` is asserted in the same cycle the offending bit would have appeared, for exactly one cycle.
- Reset values: `valid_out`=0, `data_out`=0, `stuff_err`=0, `ones_cnt`=0, state=RUN.
- `rst` wins over every simultaneous event. A frame interrupted by reset is discarded and `cnt` restarts at 0.
- Throughput: one input bit per cycle, no backpressure. Output rate is at most the input rate; gaps appear on `valid_out` where bits are stripped.
- `cnt` saturates at `RUN_LEN` by construction and never wraps.
- `data_out` holds its last value while `valid_out`=0.

## Configuration
- Macro `DESTUF_ABORT_EN`.
- Without it:
  - after a violation, destuffing resumes on the next bit of the same frame;
  - DISCARD is not synthesized.
- With it:
  - a violation moves the FSM to DISCARD;
  - every remaining bit of the frame is dropped (`valid_out`=0, no further `stuff_err`);
  - the FSM returns to RUN on the first cycle with `valid_in`=0;
  - `stuff_err` still pulses once, at the violation.

## Test plan
- **Reset:** assert `rst` 2 cycles mid-stream -> all outputs 0 and `ones_cnt`=0 on the cycle after the first reset edge.
- **Basic strip:** frame `1111101` with `RUN_LEN`=5 -> `valid_out` high for 6 cycles with data `111111`, one-cycle gap at the position of the `0`, `stuff_err` never asserted.
- **Long run:** 32 ones stuffed by `stuf` (ones in groups of 5, each followed by an inserted `0`), fed to `destuf` -> exactly 32 `1`s out and 6 stripped bits.
- **No false strip:** frame `11110` -> all 5 bits forwarded and `ones_cnt` returns to 0.
- **Violation:** frame `1111111` then `0011`:
  - without the macro: `stuff_err` pulses once at bit 6, bit 7 is forwarded, then `0011` is forwarded;
  - with `DESTUF_ABORT_EN`: no output after bit 5 until the frame ends.
- **Frame boundary and random loopback:** `11111`, then `valid_in`=0 for 1 cycle, then `1` -> that `1` is forwarded as payload, not treated as a stuffed position. Then run 500 random frames of length 12..40 through `stuf`->`destuf`; output must equal input bit-for-bit with no `stuff_err`.
